// File: rtl/simple_arbiter_sv.sv
// Round-robin arbiter that funnels N_REQ valid/ready requesters into one registered
// output slot, sustaining one word per cycle when downstream keeps out_ready high.
module simple_arbiter_sv #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ*DW-1:0]      d_in,
    input  logic [N_REQ-1:0]         in_valid,
    output logic [N_REQ-1:0]         in_ready,
    output logic [DW-1:0]            d_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_REQ)-1:0] grant_id
);
    localparam int IW = $clog2(N_REQ);

    logic [DW-1:0] din_arr [N_REQ];
    logic [DW-1:0] data_p0;
    logic [IW-1:0] gid_p0;
    logic          vld_p0;
    logic [IW-1:0] ptr;

    logic          slot_free;
    logic          found;
    logic          take;
    logic [IW-1:0] win;
    logic [IW:0]   cand;
    logic [IW:0]   nxt;
    logic [IW-1:0] ptr_nxt;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign din_arr[g] = d_in[g*DW +: DW];
    end

    assign slot_free = !vld_p0 || out_ready;

    // Priority search from ptr upward, wrapping; only the winner's data is ever selected
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!found && in_valid[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        take     = slot_free && found && !rst;
        in_ready = '0;
        if (take) begin
            in_ready[win] = 1'b1;
        end
        nxt = {1'b0, win} + (IW+1)'(1);
        if (nxt == (IW+1)'(N_REQ)) begin
            nxt = '0;
        end
        ptr_nxt = nxt[IW-1:0];
    end

    // Stage p0: output slot and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            gid_p0  <= '0;
            ptr     <= '0;
        end else if (take) begin
            vld_p0  <= 1'b1;
            data_p0 <= din_arr[win];
            gid_p0  <= win;
            ptr     <= ptr_nxt;
        end else if (out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign d_out     = data_p0;
    assign grant_id  = gid_p0;
    assign out_valid = vld_p0;

endmodule

// File: tb/tb_simple_arbiter_sv.sv
// Directed bench for simple_arbiter_sv: expected words queued at issue time, popped and
// compared by a monitor whenever the output handshakes.
module tb_simple_arbiter_sv;
    localparam int N_REQ = 4;
    localparam int DW    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_REQ*DW-1:0] d_in;
    logic [N_REQ-1:0]  in_valid;
    logic [N_REQ-1:0]  in_ready;
    logic [DW-1:0]     d_out;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb [$];

    simple_arbiter_sv #(.N_REQ(N_REQ), .DW(DW)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
        .d_out(d_out), .out_valid(out_valid), .out_ready(out_ready), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] g);
        sb.push_back({6'd0, g, d});
    endtask

    logic [7:0] rr_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [1:0] rr_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] rr_r [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        logic [15:0] e;
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_word", {16'd0, grant_id, 6'd0, d_out}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_d_out", {24'd0, d_out}, {24'd0, e[7:0]});
                        chk("sb_grant_id", {30'd0, grant_id}, {30'd0, e[9:8]});
                    end
                end
            end
        join_none

        // Reset with all requesters asking
        rst = 1'b1; in_valid = 4'b1111; d_in = 32'h0102_0304; out_ready = 1'b0;
        step();
        chk("rst_in_ready_c1", {28'd0, in_ready}, 32'd0);
        step();
        chk("rst_in_ready_c2", {28'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d_out", {24'd0, d_out}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);

        // Round-robin with all valid, full throughput
        rst = 1'b0; d_in = {8'h44, 8'h33, 8'h22, 8'h11}; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_in_ready", {28'd0, in_ready}, {28'd0, rr_r[i]});
            push(rr_d[i], rr_g[i]);
            step();
            chk("rr_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 4'b0000;
        #1;
        chk("idle_in_ready", {28'd0, in_ready}, 32'd0);
        step();
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_d_out_kept", {24'd0, d_out}, 32'h11);

        // Stall: A5 from requester 2 held while requester 3 waits (ptr=1)
        d_in = 'x; d_in[23:16] = 8'hA5; in_valid = 4'b0100; out_ready = 1'b0;
        #1;
        chk("stall_accept", {28'd0, in_ready}, 32'b0100);
        push(8'hA5, 2'd2);
        step();
        d_in = 'x; d_in[31:24] = 8'hB6; in_valid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", {28'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_d_out", {24'd0, d_out}, 32'hA5);
            chk("stall_grant_id", {30'd0, grant_id}, 32'd2);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", {28'd0, in_ready}, 32'b1000);
        push(8'hB6, 2'd3);
        step();

        // Pointer wrap: 0 wins after 3, then 3 wins after 0
        d_in = {8'hC3, 8'hxx, 8'hxx, 8'hC0}; in_valid = 4'b1001;
        #1;
        chk("wrap_first", {28'd0, in_ready}, 32'b0001);
        push(8'hC0, 2'd0);
        step();
        chk("wrap_second", {28'd0, in_ready}, 32'b1000);
        push(8'hC3, 2'd3);
        step();

        // Sparse: requester 1 alone, others' data unknown
        d_in = 'x; d_in[15:8] = 8'h5A; in_valid = 4'b0010;
        #1;
        chk("sparse_in_ready", {28'd0, in_ready}, 32'b0010);
        push(8'h5A, 2'd1);
        step();
        in_valid = 4'b0000;
        #1;
        chk("sparse_in_ready_off", {28'd0, in_ready}, 32'd0);
        chk("sparse_d_out", {24'd0, d_out}, 32'h5A);
        chk("sparse_grant_id", {30'd0, grant_id}, 32'd1);
        step();
        chk("sparse_out_valid_clr", {31'd0, out_valid}, 32'd0);

        // Reset mid-stall: the held 77 is discarded, so nothing is queued for it
        d_in = 'x; d_in[15:8] = 8'h77; in_valid = 4'b0010; out_ready = 1'b0;
        #1;
        chk("mid_accept", {28'd0, in_ready}, 32'b0010);
        step();
        in_valid = 4'b0000;
        #1;
        chk("mid_held_d_out", {24'd0, d_out}, 32'h77);
        rst = 1'b1; in_valid = 4'b1111;
        #1;
        chk("rst_forces_in_ready", {28'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0; d_in = {8'h93, 8'h92, 8'hxx, 8'hxx}; in_valid = 4'b1100; out_ready = 1'b1;
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_d_out", {24'd0, d_out}, 32'd0);
        chk("post_rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("post_rst_winner", {28'd0, in_ready}, 32'b0100);
        push(8'h92, 2'd2);
        step();
        in_valid = 4'b0000;
        step();
        step();
        chk("sb_empty_at_end", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end
endmodule
